// File: rtl/mux_response_checker_if.sv
// Bus between a vector source and the response checker: table load, run control, DUT output and results.
// The master side drives stimulus and table writes; the slave side is the checker.
interface mux_response_checker_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 6
);
    logic                  load_en;
    logic [ADDR_W-1:0]     load_addr;
    logic [2*WIDTH-1:0]    load_data;
    logic [ADDR_W-1:0]     last_index;
    logic                  start;
    logic                  sample;
    logic [WIDTH-1:0]      dut_out;
    logic [ADDR_W-1:0]     vector_index;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [ADDR_W:0]       error_count;
    logic                  fail_valid;
    logic [ADDR_W-1:0]     first_fail_index;

    modport master (
        output load_en, load_addr, load_data, last_index, start, sample, dut_out,
        input  vector_index, busy, done, pass, error_count, fail_valid, first_fail_index
    );

    modport slave (
        input  load_en, load_addr, load_data, last_index, start, sample, dut_out,
        output vector_index, busy, done, pass, error_count, fail_valid, first_fail_index
    );
endinterface

// File: rtl/mux_response_checker.sv
// Masked expected-value checker: each sampled DUT output is compared to the table entry at vector_index.
// Results update one edge after the sample; no backpressure, unsampled cycles simply hold the run.
module mux_response_checker #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    mux_response_checker_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [2*WIDTH-1:0]    r_table [DEPTH];
    logic [ADDR_W-1:0]     r_vector_index, w_vector_index_nxt;
    logic [ADDR_W-1:0]     r_end_idx, w_end_idx_nxt;
    logic [ADDR_W-1:0]     r_first_fail_index, w_first_fail_index_nxt;
    logic [ADDR_W:0]       r_error_count, w_error_count_nxt;
    logic                  r_fail_valid, w_fail_valid_nxt;

    logic [2*WIDTH-1:0]    w_entry;
    logic [WIDTH-1:0]      w_expected;
    logic [WIDTH-1:0]      w_care_mask;
    logic                  w_mismatch;
    logic                  w_load_ok;

    assign w_entry     = r_table[r_vector_index];
    assign w_expected  = w_entry[WIDTH-1:0];
    assign w_care_mask = w_entry[2*WIDTH-1:WIDTH];
    assign w_mismatch  = |((bus.dut_out ^ w_expected) & w_care_mask);

    // The table survives reset so a reset between runs does not force a reload.
    assign w_load_ok = bus.load_en && (r_state != S_RUN);

    always_ff @(posedge i_clk) begin
        if (w_load_ok) begin
            r_table[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state            <= S_IDLE;
            r_vector_index     <= '0;
            r_end_idx          <= '0;
            r_first_fail_index <= '0;
            r_error_count      <= '0;
            r_fail_valid       <= 1'b0;
        end else begin
            r_state            <= w_state_nxt;
            r_vector_index     <= w_vector_index_nxt;
            r_end_idx          <= w_end_idx_nxt;
            r_first_fail_index <= w_first_fail_index_nxt;
            r_error_count      <= w_error_count_nxt;
            r_fail_valid       <= w_fail_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt            = r_state;
        w_vector_index_nxt     = r_vector_index;
        w_end_idx_nxt          = r_end_idx;
        w_first_fail_index_nxt = r_first_fail_index;
        w_error_count_nxt      = r_error_count;
        w_fail_valid_nxt       = r_fail_valid;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt            = S_RUN;
                    w_vector_index_nxt     = '0;
                    w_end_idx_nxt          = bus.last_index;
                    w_first_fail_index_nxt = '0;
                    w_error_count_nxt      = '0;
                    w_fail_valid_nxt       = 1'b0;
                end
            end
            S_RUN: begin
                if (bus.sample) begin
                    if (w_mismatch) begin
                        w_error_count_nxt = r_error_count + (ADDR_W+1)'(1);
                        if (!r_fail_valid) begin
                            w_fail_valid_nxt       = 1'b1;
                            w_first_fail_index_nxt = r_vector_index;
                        end
                    end
                    // Index holds on the final vector so it never wraps.
                    if (r_vector_index == r_end_idx) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_vector_index_nxt = r_vector_index + ADDR_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.vector_index     = r_vector_index;
    assign bus.busy             = (r_state == S_RUN);
    assign bus.done             = (r_state == S_DONE);
    assign bus.pass             = (r_state == S_DONE) && (r_error_count == '0);
    assign bus.error_count      = r_error_count;
    assign bus.fail_valid       = r_fail_valid;
    assign bus.first_fail_index = r_first_fail_index;
endmodule

// File: tb/tb_mux_response_checker.sv
// Directed bench for mux_response_checker: pass, injected errors, masking, gapped sampling, reset abort, ignored events.
module tb_mux_response_checker;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   nsteps;
    logic [3:0] drv [64];

    mux_response_checker_if #(.WIDTH(4), .ADDR_W(6)) bus ();

    mux_response_checker #(.WIDTH(4), .ADDR_W(6)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int addr, input logic [7:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = 6'(addr);
        bus.load_data = data;
        step();
        bus.load_en   = 1'b0;
    endtask

    task automatic set_drv_pass(input int n);
        for (int i = 0; i < n; i++) drv[i] = 4'(i);
    endtask

    // Runs vectors 0..last using drv[] as DUT output; optionally writes entry 0 in the start cycle,
    // and at step poke_at pulses start and load_en, both of which must be ignored.
    task automatic run(input int last, input bit gapped, input bit ld_start, input int poke_at,
                       output int steps);
        int k;
        bit s;
        bus.last_index = 6'(last);
        bus.start      = 1'b1;
        if (ld_start) begin
            bus.load_en   = 1'b1;
            bus.load_addr = 6'd0;
            bus.load_data = {4'hF, 4'h0};
        end
        step();
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_vidx", bus.vector_index, 0);
        chk("start_errcnt", bus.error_count, 0);
        chk("start_failvld", bus.fail_valid, 0);
        k     = 0;
        steps = 0;
        while (k <= last && steps < 300) begin
            s           = gapped ? steps[0] : 1'b1;
            bus.sample  = s;
            bus.dut_out = drv[k];
            if (steps == poke_at) begin
                bus.start      = 1'b1;
                bus.last_index = 6'd0;
                bus.load_en    = 1'b1;
                bus.load_addr  = 6'd5;
                bus.load_data  = {4'hF, 4'hA};
            end
            step();
            steps++;
            bus.sample  = 1'b0;
            bus.start   = 1'b0;
            bus.load_en = 1'b0;
            if (s) k++;
            chk("run_vidx", bus.vector_index, (k > last) ? last : k);
        end
        chk("run_complete", k, last + 1);
        chk("end_done", bus.done, 1);
        chk("end_busy", bus.busy, 0);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus.load_en    = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        bus.last_index = '0;
        bus.start      = 1'b0;
        bus.sample     = 1'b0;
        bus.dut_out    = '0;
        step();
        step();
        reset = 1'b0;

        chk("rst_vidx", bus.vector_index, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_errcnt", bus.error_count, 0);
        chk("rst_failvld", bus.fail_valid, 0);
        chk("rst_ffi", bus.first_fail_index, 0);

        // Entry 0 starts wrong; the write issued alongside start must be what index 0 compares against.
        load(0, {4'hF, 4'h5});
        for (int i = 1; i < 8; i++) load(i, {4'hF, 4'(i)});

        set_drv_pass(8);
        run(7, 1'b0, 1'b1, -1, nsteps);
        chk("allpass_steps", nsteps, 8);
        chk("allpass_pass", bus.pass, 1);
        chk("allpass_errcnt", bus.error_count, 0);
        chk("allpass_failvld", bus.fail_valid, 0);
        chk("allpass_vidx", bus.vector_index, 7);

        // Restart from DONE with errors at 3 and 6.
        drv[3] = 4'hF;
        drv[6] = 4'hF;
        run(7, 1'b0, 1'b0, -1, nsteps);
        chk("inject_errcnt", bus.error_count, 2);
        chk("inject_ffi", bus.first_fail_index, 3);
        chk("inject_failvld", bus.fail_valid, 1);
        chk("inject_pass", bus.pass, 0);

        set_drv_pass(8);
        run(7, 1'b0, 1'b0, 2, nsteps);
        chk("ignored_steps", nsteps, 8);
        chk("ignored_errcnt", bus.error_count, 0);
        chk("ignored_pass", bus.pass, 1);

        run(7, 1'b1, 1'b0, -1, nsteps);
        chk("gapped_steps", nsteps, 16);
        chk("gapped_pass", bus.pass, 1);
        chk("gapped_errcnt", bus.error_count, 0);

        load(0, {4'b0011, 4'b0001});
        drv[0] = 4'b1101;
        run(0, 1'b0, 1'b0, -1, nsteps);
        chk("mask_steps", nsteps, 1);
        chk("mask_pass", bus.pass, 1);
        chk("mask_errcnt", bus.error_count, 0);
        drv[0] = 4'b0000;
        run(0, 1'b0, 1'b0, -1, nsteps);
        chk("mask_fail_errcnt", bus.error_count, 1);
        chk("mask_fail_pass", bus.pass, 0);
        chk("mask_fail_ffi", bus.first_fail_index, 0);

        // Full table: expected = index low nibble, all bits cared.
        for (int i = 0; i < 64; i++) load(i, {4'hF, 4'(i)});
        for (int i = 0; i < 64; i++) drv[i] = 4'(i);
        drv[1] = ~4'h1;
        drv[2] = ~4'h2;
        bus.last_index = 6'd63;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.sample  = 1'b1;
            bus.dut_out = drv[i];
            step();
        end
        bus.sample = 1'b0;
        chk("prerst_vidx", bus.vector_index, 4);
        chk("prerst_errcnt", bus.error_count, 2);
        chk("prerst_ffi", bus.first_fail_index, 1);
        reset       = 1'b1;
        bus.sample  = 1'b1;
        bus.dut_out = drv[4];
        step();
        reset      = 1'b0;
        bus.sample = 1'b0;
        chk("abort_vidx", bus.vector_index, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_pass", bus.pass, 0);
        chk("abort_errcnt", bus.error_count, 0);
        chk("abort_failvld", bus.fail_valid, 0);
        chk("abort_ffi", bus.first_fail_index, 0);

        for (int i = 0; i < 64; i++) drv[i] = 4'(i);
        drv[10] = ~4'hA;
        drv[20] = ~4'h4;
        drv[63] = ~4'hF;
        run(63, 1'b0, 1'b0, -1, nsteps);
        chk("full_steps", nsteps, 64);
        chk("full_vidx", bus.vector_index, 63);
        chk("full_errcnt", bus.error_count, 3);
        chk("full_ffi", bus.first_fail_index, 10);
        chk("full_pass", bus.pass, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux_response_checker.md
# mux_response_checker

Synthesizable response checker that closes the loop on vector-driven block tests in the single-cycle processor. It holds a preloaded table of expected outputs with per-bit care masks. After `start`, it compares the device-under-test output against the table entry for the current vector index on every sampled cycle. It reports the error count, the index of the first mismatch, and a pass/fail verdict, so mux, ALU and decoder checks can run on hardware without a simulator-side comparison.

## Interface
- `WIDTH`, 4: width of the checked DUT output.
- `ADDR_W`, 6: vector index width; the table holds 2^ADDR_W entries (64).
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `load_en`  input  1  table write strobe.
- `load_addr`  input  ADDR_W  table write address.
- `load_data`  input  2*WIDTH  table entry: {care_mask[WIDTH-1:0], expected[WIDTH-1:0]}.
- `last_index`  input  ADDR_W  index of the final vector in a run; sampled at `start`.
- `start`  input  1  one-cycle pulse that begins a run.
- `sample`  input  1  the DUT output is valid this cycle for the current vector.
- `dut_out`  input  WIDTH  the DUT output under check.
- `vector_index`  output  ADDR_W  index currently being checked.
- `busy`  output  1  high while in RUN.
- `done`  output  1  high in DONE.
- `pass`  output  1  high in DONE when `error_count` is 0.
- `error_count`  output  ADDR_W+1  number of mismatching vectors.
- `fail_valid`  output  1  at least one mismatch has been recorded.
- `first_fail_index`  output  ADDR_W  index of the first mismatch.

## Operation
- Table: a 2^ADDR_W x 2*WIDTH register array with combinational read at `vector_index`.
  - The table is not cleared by reset.
  - A write occurs when `load_en` is high and the FSM is in IDLE or DONE. Writes during RUN are ignored.
- Mismatch condition: `((dut_out ^ expected) & care_mask) != 0`. A zero mask means the vector always passes.
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN on `start`.
    - Clears `error_count`, `fail_valid` and `first_fail_index`.
    - Sets `vector_index` to 0.
    - Latches `last_index` into an internal `end_idx`.
  - RUN, `sample` high:
    - Compare against the current entry.
    - On mismatch, increment `error_count`. If `fail_valid` is 0, load `first_fail_index` with `vector_index` and set `fail_valid`.
    - If `vector_index == end_idx`, go to DONE and hold `vector_index`. Otherwise increment `vector_index`.
  - RUN, `sample` low: no change.
  - `start` during RUN is ignored.
  - DONE holds all results. `start` in DONE behaves exactly as in IDLE, which restarts the run.
- Width rules:
  - `error_count` is ADDR_W+1 bits. Its maximum of 2^ADDR_W cannot overflow.
  - `vector_index` never wraps within a run, because the run terminates at `end_idx`.
  - `last_index` = 2^ADDR_W-1 checks the full table.

## Timing
- Reset values: state IDLE; `vector_index` 0; `busy`, `done`, `pass`, `fail_valid` 0; `error_count` 0; `first_fail_index` 0.
- Reset during RUN aborts the run in the same edge and returns the block to the reset values.
- `start` at edge N: `busy` = 1 and `vector_index` = 0 after edge N. The first comparison uses `sample` at edge N+1.
- Compare latency is one cycle. `error_count` and `fail_valid` reflect the sample taken at edge k immediately after edge k.
- Completion:
  - The last sample at edge k gives `busy` = 0 and `done` = 1 after edge k.
  - `pass` is valid in the same cycle as `done` and includes the last vector.
- Minimum run with `sample` held high is `last_index`+1 cycles, plus one cycle for `start`.
- `load_en` and `start` in the same cycle from IDLE: the write completes and the run starts. The written entry is visible to the first compare.

## Test plan
- All-pass run:
  - Stimulus: load 8 entries with mask 4'hF and expected 0..7; `last_index` = 7; drive `dut_out` = index with `sample` held high.
  - Required: `done` after 8 samples, `pass` = 1, `error_count` = 0, `fail_valid` = 0.
- Injected errors:
  - Stimulus: same table; drive `dut_out` = 4'hF at indices 3 and 6.
  - Required: `error_count` = 2, `first_fail_index` = 3, `pass` = 0.
- Masking:
  - Stimulus: entry 0 = {4'b0011, 4'b0001}; `dut_out` = 4'b1101; `last_index` = 0.
  - Required: pass. Changing `dut_out` to 4'b0000 gives `error_count` = 1.
- Gapped sampling:
  - Stimulus: toggle `sample` every other cycle on the 8-vector all-pass table.
  - Required: `vector_index` advances only on sampled cycles; `done` after 8 samples (about 16 cycles); `pass` = 1.
- Reset and restart:
  - Stimulus: assert `reset` at index 4 of a failing run; release; pulse `start` with `last_index` = 63 on a full 64-entry table.
  - Required: all outputs at reset values after the reset edge; the restarted run checks indices 0..63 and ends with `error_count` equal to the number of injected errors.
- Ignored events:
  - Stimulus: pulse `start` and `load_en` mid-run.
  - Required: the run is unaffected and the table contents are unchanged.
